// File: rtl/tug_center_input_if.sv
// Playfield I/O bundle for the tug-of-war center input block: raw buttons and
// neighbour light states in, move pulses and center light state out.
interface tug_center_input_if;
    logic press_l;
    logic press_r;
    logic NL;
    logic NR;
    logic L;
    logic R;
    logic lightOn;

    modport master (
        output press_l,
        output press_r,
        output NL,
        output NR,
        input  L,
        input  R,
        input  lightOn
    );

    modport slave (
        input  press_l,
        input  press_r,
        input  NL,
        input  NR,
        output L,
        output R,
        output lightOn
    );
endinterface

// File: rtl/tug_center_input.sv
// Button synchronizers, one-shot press detectors and the center-light FSM.
// Optional macro TUG_SYNC3_EN lengthens each synchronizer to 3 flops.
module tug_center_input (
    input  logic                clk,
    input  logic                reset,
    tug_center_input_if.slave   bus
);

`ifdef TUG_SYNC3_EN
    localparam int SYNC_W = 3;
`else
    localparam int SYNC_W = 2;
`endif

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } state_t;

    logic [SYNC_W-1:0] r_sync_l;
    logic [SYNC_W-1:0] r_sync_r;
    logic              r_prev_l;
    logic              r_prev_r;
    logic              r_pulse_l;
    logic              r_pulse_r;
    state_t            r_state;
    logic              w_sync_l;
    logic              w_sync_r;

    assign w_sync_l = r_sync_l[SYNC_W-1];
    assign w_sync_r = r_sync_r[SYNC_W-1];

    // Bring both asynchronous button levels into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_l <= {SYNC_W{1'b0}};
            r_sync_r <= {SYNC_W{1'b0}};
        end else begin
            r_sync_l <= {r_sync_l[SYNC_W-2:0], bus.press_l};
            r_sync_r <= {r_sync_r[SYNC_W-2:0], bus.press_r};
        end
    end

    // prev resets low, so a button already held at reset release still yields one pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_l  <= 1'b0;
            r_prev_r  <= 1'b0;
            r_pulse_l <= 1'b0;
            r_pulse_r <= 1'b0;
        end else begin
            r_prev_l  <= w_sync_l;
            r_prev_r  <= w_sync_r;
            r_pulse_l <= w_sync_l & ~r_prev_l;
            r_pulse_r <= w_sync_r & ~r_prev_r;
        end
    end

    // Center light: leaves on a lone pulse, returns only from the neighbour that pushes it back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_ON;
        end else begin
            case (r_state)
                ST_ON: begin
                    if (r_pulse_l ^ r_pulse_r) begin
                        r_state <= ST_OFF;
                    end else begin
                        r_state <= ST_ON;
                    end
                end
                ST_OFF: begin
                    if ((bus.NL & r_pulse_r & ~r_pulse_l) |
                        (bus.NR & r_pulse_l & ~r_pulse_r)) begin
                        r_state <= ST_ON;
                    end else begin
                        r_state <= ST_OFF;
                    end
                end
                default: begin
                    r_state <= ST_ON;
                end
            endcase
        end
    end

    assign bus.L       = r_pulse_l;
    assign bus.R       = r_pulse_r;
    assign bus.lightOn = (r_state == ST_ON);

endmodule

// File: tb/tb_tug_center_input.sv
// Directed bench for tug_center_input; honours TUG_SYNC3_EN for latency and press width.
module tb_tug_center_input;

`ifdef TUG_SYNC3_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int PW = LAT;      // minimum guaranteed press width
    localparam int P  = LAT + 1;  // tick index (edge k = tick 1) where the pulse is seen

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    tug_center_input_if io ();

    tug_center_input dut (
        .clk   (clk),
        .reset (reset),
        .bus   (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press the selected buttons for width cycles, then idle; count pulses and note first pulse tick.
    task automatic do_press(input logic pl, input logic pr, input int width,
                            output int cl, output int cr, output int fl, output int fr);
        cl = 0; cr = 0; fl = -1; fr = -1;
        io.press_l = pl;
        io.press_r = pr;
        for (int i = 1; i <= width + 8; i++) begin
            if (i == width + 1) begin
                io.press_l = 1'b0;
                io.press_r = 1'b0;
            end
            tick();
            if (io.L === 1'b1) begin
                cl++;
                if (fl < 0) fl = i;
            end
            if (io.R === 1'b1) begin
                cr++;
                if (fr < 0) fr = i;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cl, cr, fl, fr;
        n_total = 0;
        n_bad   = 0;
        io.press_l = 1'b0;
        io.press_r = 1'b0;
        io.NL      = 1'b0;
        io.NR      = 1'b0;
        reset      = 1'b1;
        #2;
        check("rst_L", {31'd0, io.L}, 32'd0);
        check("rst_R", {31'd0, io.R}, 32'd0);
        check("rst_light", {31'd0, io.lightOn}, 32'd1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();

        // Single left press with explicit per-cycle timing
        io.press_l = 1'b1;
        for (int i = 1; i <= P + 2; i++) begin
            if (i == PW + 1) io.press_l = 1'b0;
            tick();
            check("single_L", {31'd0, io.L}, (i == P) ? 32'd1 : 32'd0);
            check("single_R", {31'd0, io.R}, 32'd0);
            check("single_light", {31'd0, io.lightOn}, (i <= P) ? 32'd1 : 32'd0);
        end
        repeat (4) tick();

        // lightOn=0, NL=1, L pulse: stays off
        io.NL = 1'b1;
        do_press(1'b1, 1'b0, PW, cl, cr, fl, fr);
        check("nl_L_cnt", cl, 32'd1);
        check("nl_L_light", {31'd0, io.lightOn}, 32'd0);
        // lightOn=0, NL=1, R pulse: returns
        do_press(1'b0, 1'b1, PW, cl, cr, fl, fr);
        check("nl_R_cnt", cr, 32'd1);
        check("nl_R_light", {31'd0, io.lightOn}, 32'd1);
        io.NL = 1'b0;
        // Leave to the right, then NR=1 with L pulse returns
        do_press(1'b0, 1'b1, PW, cl, cr, fl, fr);
        check("leave_R_light", {31'd0, io.lightOn}, 32'd0);
        io.NR = 1'b1;
        do_press(1'b1, 1'b0, PW, cl, cr, fl, fr);
        check("nr_L_light", {31'd0, io.lightOn}, 32'd1);
        io.NR = 1'b0;
        do_press(1'b1, 1'b0, PW, cl, cr, fl, fr);
        check("leave_L_light", {31'd0, io.lightOn}, 32'd0);
        // No neighbour: either pulse keeps it off
        do_press(1'b0, 1'b1, PW, cl, cr, fl, fr);
        check("none_R_light", {31'd0, io.lightOn}, 32'd0);
        do_press(1'b1, 1'b0, PW, cl, cr, fl, fr);
        check("none_L_light", {31'd0, io.lightOn}, 32'd0);

        // Bring light back on, then simultaneous press leaves it on
        io.NL = 1'b1;
        do_press(1'b0, 1'b1, PW, cl, cr, fl, fr);
        check("back_on_light", {31'd0, io.lightOn}, 32'd1);
        io.NL = 1'b0;
        do_press(1'b1, 1'b1, PW, cl, cr, fl, fr);
        check("simul_cntL", cl, 32'd1);
        check("simul_cntR", cr, 32'd1);
        check("simul_firstL", fl, P);
        check("simul_firstR", fr, P);
        check("simul_light", {31'd0, io.lightOn}, 32'd1);

        // Long hold then re-press: one pulse each, re-press at normal latency
        do_press(1'b0, 1'b1, 20, cl, cr, fl, fr);
        check("hold_cntR", cr, 32'd1);
        check("hold_cntL", cl, 32'd0);
        check("hold_light", {31'd0, io.lightOn}, 32'd0);
        do_press(1'b0, 1'b1, PW, cl, cr, fl, fr);
        check("repress_cntR", cr, 32'd1);
        check("repress_firstR", fr, P);
        check("repress_light", {31'd0, io.lightOn}, 32'd0);

        // Asynchronous reset mid-pulse with lightOn=0 and press_l held
        io.press_l = 1'b1;
        for (int i = 1; i <= P; i++) tick();
        check("pre_rst_L", {31'd0, io.L}, 32'd1);
        check("pre_rst_light", {31'd0, io.lightOn}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_L", {31'd0, io.L}, 32'd0);
        check("async_rst_R", {31'd0, io.R}, 32'd0);
        check("async_rst_light", {31'd0, io.lightOn}, 32'd1);
        tick();
        tick();
        check("rst_hold_light", {31'd0, io.lightOn}, 32'd1);
        reset = 1'b0;
        do_press(1'b1, 1'b0, 6, cl, cr, fl, fr);
        check("post_rst_cntL", cl, 32'd1);
        check("post_rst_firstL", fl, P);
        check("post_rst_light", {31'd0, io.lightOn}, 32'd0);

        // One-cycle glitch with NR=1: at most one pulse, light follows the count
        io.NR = 1'b1;
        do_press(1'b1, 1'b0, 1, cl, cr, fl, fr);
        check("glitch_le1", (cl <= 1) ? 32'd1 : 32'd0, 32'd1);
        check("glitch_light", {31'd0, io.lightOn}, (cl == 1) ? 32'd1 : 32'd0);
        io.NR = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tug_center_input.md
# tug_center_input

Input-conditioning and center-position block for the tug-of-war playfield. It takes the two players' raw asynchronous push-button levels and passes each through a synchronizer and a one-shot press detector. The resulting single-cycle move pulses are exported to the rest of the playfield lights. Internally the pulses drive the center-light state machine, which owns the middle LED of the field.

## Interface
Parameters: none.
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high; clears or presets all state immediately
- press_l  input  1  left player button, active-high level, asynchronous to clk
- press_r  input  1  right player button, active-high level, asynchronous to clk
- NL  input  1  lightOn of the left-neighbour light
- NR  input  1  lightOn of the right-neighbour light
- L  output  1  registered one-cycle pulse, one per left press; drives all playfield lights
- R  output  1  registered one-cycle pulse, one per right press; drives all playfield lights
- lightOn  output  1  center light state

## Operation
- **Synchronizer (per button):** 2-flop chain, both flops reset to 0. Its output is the synchronized level.
- **Press detector (per button):** holds prev = the last synchronized level, reset 0.
  - Pulse register is set to sync & ~prev on each clock; reset value 0.
  - Holding a button for any length of time produces exactly one pulse.
  - Release produces nothing.
  - A button already held when reset deasserts produces one pulse (prev resets to 0).
- **Center light:** 2-state FSM, ON/OFF; reset state ON.
  - ON → OFF when L ^ R (the light leaves toward either side).
  - OFF → ON when (NL & R & ~L) | (NR & L & ~R) (the light arrives from a neighbour).
  - All other combinations hold the current state.
  - L & R together: no change in either state.
  - NL & NR together: the L/R exclusivity terms decide as above.
- lightOn = (state == ON).

## Timing
- Reset values:
  - L = 0, R = 0, lightOn = 1.
  - All synchronizer and prev flops = 0.
- Reset acts asynchronously. Deassertion mid-operation resumes from these values on the next edge.
- Latency, press to pulse: a press_x rising level captured at edge k sets the pulse at edge k+2, and it is high for exactly one cycle. This assumes setup is met at edge k; otherwise add one cycle.
- The FSM samples L/R at the edge following the pulse, so lightOn changes at edge k+3.
- Minimum press width for guaranteed detection: 2 clk periods.
- Minimum release width between presses: 2 clk periods.
- Pulse spacing: at most one pulse per button per 2 cycles.
- L and R are fully independent. Simultaneous presses yield simultaneous pulses.
- Pulses leave through registers; no combinational path from press_x to L/R.
- NL and NR are used combinationally in next-state logic only, with no added latency.

## Configuration
- **TUG_SYNC3_EN defined:** each synchronizer is 3 flops.
  - All press-to-pulse latencies grow by 1 cycle: pulse at edge k+3, lightOn change at edge k+4.
  - Minimum press and release widths grow to 3 cycles.
- **Undefined:** 2-flop synchronizer, with the timing stated above.
- FSM behaviour is identical in both builds.

## Test plan
- **Reset:** assert reset mid-stream with lightOn=0 and press_l held → L=R=0 and lightOn=1 immediately (asynchronous); hold for 2 cycles.
- **Single left press:** press_l held 2 cycles from edge k, NL=NR=0 → L=1 only during the cycle after edge k+2, R stays 0, lightOn=0 from edge k+3.
- **Long hold:** press_r held 20 cycles, released, then held again → exactly two one-cycle R pulses, the second 2 cycles after the re-press.
- **Simultaneous press:** press_l and press_r rise at the same edge with lightOn=1 → L and R pulse in the same cycle; lightOn stays 1.
- **Return to center:**
  - lightOn=0, NL=1, R pulse → lightOn=1.
  - lightOn=0, NR=1, L pulse → lightOn=1.
  - lightOn=0, NL=1, L pulse → stays 0.
  - lightOn=0, NL=NR=0, either pulse → stays 0.
- **Short glitch:** press_l high for 1 cycle, not straddling a setup window → at most one L pulse, never two; lightOn consistent with the pulse count.
